// File: rtl/mouse_axis_pkg.sv
// Shared definitions for the mouse-to-analog axis emulator: packet field
// positions, per-port mode encoding and the saturating accumulate helper.
package mouse_axis_pkg;

  localparam int STB    = 24;
  localparam int DY_HI  = 23;
  localparam int DY_LO  = 16;
  localparam int DX_HI  = 15;
  localparam int DX_LO  = 8;
  localparam int YS     = 5;
  localparam int XS     = 4;
  localparam int BTN_HI = 1;
  localparam int BTN_LO = 0;

  typedef enum logic {
    PM_ANALOG = 1'b0,
    PM_MOUSE  = 1'b1
  } port_mode_t;

  // Adds at full 32-bit width, then saturates to a signed range of 'width' bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                 input logic signed [31:0] delta,
                                                 input int width);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = acc + delta;
    hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo  = -hi - 32'sd1;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// One signed emulated axis: scales and clamps a raw 9-bit mouse delta, then
// accumulates with saturation; clear and a one-step recentre are also handled.
module mouse_axis_acc
  import mouse_axis_pkg::*;
#(
  parameter int AXIS_W   = 8,
  parameter int MAX_STEP = 10,
  parameter int SHIFT    = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_mag,
  input  logic                     i_sign,
  input  logic                     i_apply,
  input  logic                     i_clr,
  input  logic                     i_decay,
  output logic signed [AXIS_W-1:0] o_nxt
);

  logic signed [AXIS_W-1:0] r_acc;
  logic signed [8:0]        w_raw;
  logic signed [8:0]        w_shr;
  logic signed [31:0]       w_ext;
  logic signed [31:0]       w_step;
  logic signed [31:0]       w_sum;

  assign w_raw = {i_sign, i_mag};
  assign w_shr = w_raw >>> SHIFT;
  assign w_ext = {{23{w_shr[8]}}, w_shr};

  // Symmetric magnitude clamp on the scaled delta.
  always_comb begin
    w_step = w_ext;
    if (w_ext > MAX_STEP) begin
      w_step = MAX_STEP;
    end else if (w_ext < -MAX_STEP) begin
      w_step = -MAX_STEP;
    end else begin
      w_step = w_ext;
    end
  end

  assign w_sum = sat_add({{(32-AXIS_W){r_acc[AXIS_W-1]}}, r_acc}, w_step, AXIS_W);

  // Clear beats a packet, and a packet beats the recentre step.
  always_comb begin
    o_nxt = r_acc;
    if (i_clr) begin
      o_nxt = '0;
    end else if (i_apply) begin
      o_nxt = w_sum[AXIS_W-1:0];
    end else if (i_decay && (r_acc != '0)) begin
      o_nxt = r_acc[AXIS_W-1] ? (r_acc + AXIS_W'(1)) : (r_acc - AXIS_W'(1));
    end else begin
      o_nxt = r_acc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= o_nxt;
    end
  end

endmodule

// File: rtl/mouse_axis_emu.sv
// Mouse-to-analog-joystick emulator: routes PS/2 mouse motion to one port as
// absolute axes. Optional recentring decay is enabled by MOUSE_AXIS_RECENTER_EN.
module mouse_axis_emu
  import mouse_axis_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int AXIS_W    = 8,
  parameter int MAX_STEP  = 10,
  parameter int SHIFT     = 1,
  parameter int BTN_LSB   = 4,
  parameter int DECAY_DIV = 65536,
  localparam int SEL_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic [24:0]                   ps2_mouse,
  input  logic [SEL_W-1:0]              mouse_sel,
  input  logic                          halt,
  input  logic [NUM_PORTS*2*AXIS_W-1:0] joya_in,
  input  logic [NUM_PORTS*16-1:0]       joy_in,
  output logic [NUM_PORTS*AXIS_W-1:0]   ax_out,
  output logic [NUM_PORTS*AXIS_W-1:0]   ay_out,
  output logic [NUM_PORTS*16-1:0]       joy_out,
  output logic [NUM_PORTS-1:0]          mouse_active
);

  logic r_primed;
  logic r_stb;
  logic w_pkt;
  logic w_tick;
  logic w_unused;

  assign w_unused = ^{ps2_mouse[7:6], ps2_mouse[3:2], (DECAY_DIV > 0)};

  // Strobe tracker; the first cycle after reset only primes it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_primed <= 1'b0;
      r_stb    <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      r_stb    <= ps2_mouse[STB];
    end
  end

  assign w_pkt = r_primed & (ps2_mouse[STB] ^ r_stb);

`ifdef MOUSE_AXIS_RECENTER_EN
  localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  logic [DIV_W-1:0] r_div;

  // Free-running recentre divider.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (r_div == DIV_W'(DECAY_DIV - 1)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_tick = (r_div == DIV_W'(DECAY_DIV - 1));
`else
  assign w_tick = 1'b0;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_mode_t               r_mode;
    port_mode_t               w_mode_nxt;
    logic                     w_rel;
    logic                     w_take;
    logic                     w_decay;
    logic [AXIS_W-1:0]        w_jx;
    logic [AXIS_W-1:0]        w_jy;
    logic signed [AXIS_W-1:0] w_ax_nxt;
    logic signed [AXIS_W-1:0] w_ay_nxt;
    logic [15:0]              w_joy_raw;
    logic [15:0]              w_joy_btn;
    logic [15:0]              w_joy_nxt;
    logic [AXIS_W-1:0]        r_ax;
    logic [AXIS_W-1:0]        r_ay;
    logic [15:0]              r_joy;

    assign w_jx = joya_in[p*2*AXIS_W +: AXIS_W];
    assign w_jy = joya_in[p*2*AXIS_W+AXIS_W +: AXIS_W];

    // Any release condition outranks a packet arriving in the same cycle.
    assign w_rel   = halt | (|{w_jy, w_jx}) | (mouse_sel != SEL_W'(p));
    assign w_take  = w_pkt & ~w_rel;
    assign w_decay = w_tick & (r_mode == PM_MOUSE);

    mouse_axis_acc #(.AXIS_W(AXIS_W), .MAX_STEP(MAX_STEP), .SHIFT(SHIFT)) u_acc_x (
      .i_clk(clk_sys), .i_rst_n(reset_n),
      .i_mag(ps2_mouse[DX_HI:DX_LO]), .i_sign(ps2_mouse[XS]),
      .i_apply(w_take), .i_clr(w_rel), .i_decay(w_decay), .o_nxt(w_ax_nxt)
    );

    mouse_axis_acc #(.AXIS_W(AXIS_W), .MAX_STEP(MAX_STEP), .SHIFT(SHIFT)) u_acc_y (
      .i_clk(clk_sys), .i_rst_n(reset_n),
      .i_mag(ps2_mouse[DY_HI:DY_LO]), .i_sign(ps2_mouse[YS]),
      .i_apply(w_take), .i_clr(w_rel), .i_decay(w_decay), .o_nxt(w_ay_nxt)
    );

    // Port mode next-state.
    always_comb begin
      w_mode_nxt = r_mode;
      if (w_rel) begin
        w_mode_nxt = PM_ANALOG;
      end else if (w_take) begin
        w_mode_nxt = PM_MOUSE;
      end else begin
        w_mode_nxt = r_mode;
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_mode <= PM_ANALOG;
      end else begin
        r_mode <= w_mode_nxt;
      end
    end

    // An all-ones analog word means no stick is fitted, so its directions are dropped.
    assign w_joy_raw = joy_in[p*16 +: 16];
    assign w_joy_btn = (w_mode_nxt == PM_MOUSE)
                     ? ((w_joy_raw & ~(16'h0003 << BTN_LSB)) |
                        (16'(ps2_mouse[BTN_HI:BTN_LO]) << BTN_LSB))
                     : w_joy_raw;
    assign w_joy_nxt = (&{w_jy, w_jx}) ? {w_joy_btn[15:4], 4'h0} : w_joy_btn;

    // Outputs track the next mode so axes move on the edge after a packet.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_ax  <= '0;
        r_ay  <= '0;
        r_joy <= '0;
      end else begin
        r_ax  <= (w_mode_nxt == PM_MOUSE) ? w_ax_nxt : w_jx;
        r_ay  <= (w_mode_nxt == PM_MOUSE) ? w_ay_nxt : w_jy;
        r_joy <= w_joy_nxt;
      end
    end

    assign ax_out[p*AXIS_W +: AXIS_W] = r_ax;
    assign ay_out[p*AXIS_W +: AXIS_W] = r_ay;
    assign joy_out[p*16 +: 16]        = r_joy;
    assign mouse_active[p]            = (r_mode == PM_MOUSE);
  end

endmodule
